pc_predict_gen: RTL and testbench

//   IF-stage PC generator with a direct-mapped BTB and 2-bit saturating

---
 rtl/pc_predict_gen_if.sv | 28 ++
 rtl/pc_predict_gen.sv | 123 ++++++++++++
 tb/tb_pc_predict_gen.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_predict_gen_if.sv
// Fetch-side bundle for pc_predict_gen: stall/redirect control, branch
// resolution feedback from EX, and the predicted fetch address back out.
interface pc_predict_gen_if #(
  parameter int XLEN = 32
);
  logic            pc_write;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic [XLEN-1:0] pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  modport master (
    output pc_write, redirect_valid, redirect_pc,
    output upd_valid, upd_pc, upd_taken, upd_target,
    input  pc, pred_taken, pred_target
  );

  modport slave (
    input  pc_write, redirect_valid, redirect_pc,
    input  upd_valid, upd_pc, upd_taken, upd_target,
    output pc, pred_taken, pred_target
  );
endinterface

// File: rtl/pc_predict_gen.sv
// IF-stage PC generator: direct-mapped BTB with 2-bit saturating direction
// counters; next pc from redirect, stall hold, predicted target or pc+4.
module pc_predict_gen #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              BTB_ENTRIES = 16
) (
  input  logic              clk,
  input  logic              rst,
  pc_predict_gen_if.slave   bus
);

  localparam int IDX  = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  typedef enum logic [1:0] {
    CTR_STRONG_NT = 2'b00,
    CTR_WEAK_NT   = 2'b01,
    CTR_WEAK_T    = 2'b10,
    CTR_STRONG_T  = 2'b11
  } ctr_t;

  function automatic ctr_t sat_inc(input ctr_t c);
    case (c)
      CTR_STRONG_NT: sat_inc = CTR_WEAK_NT;
      CTR_WEAK_NT:   sat_inc = CTR_WEAK_T;
      default:       sat_inc = CTR_STRONG_T;
    endcase
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c);
    case (c)
      CTR_STRONG_T: sat_dec = CTR_WEAK_T;
      CTR_WEAK_T:   sat_dec = CTR_WEAK_NT;
      default:      sat_dec = CTR_STRONG_NT;
    endcase
  endfunction

  logic [XLEN-1:0]        pc_q;
  logic [XLEN-1:0]        next_pc;
  logic [BTB_ENTRIES-1:0] valid_q;
  ctr_t                   ctr_q      [BTB_ENTRIES];
  logic [TAGW-1:0]        tag_mem    [BTB_ENTRIES];
  logic [XLEN-1:0]        target_mem [BTB_ENTRIES];

  // Lookup on the current fetch address
  logic [IDX-1:0]  look_idx;
  logic [TAGW-1:0] look_tag;
  logic            look_hit;

  assign look_idx = pc_q[IDX+1:2];
  assign look_tag = pc_q[XLEN-1:IDX+2];
  assign look_hit = valid_q[look_idx] && (tag_mem[look_idx] == look_tag);

  assign bus.pc          = pc_q;
  assign bus.pred_taken  = look_hit && ctr_q[look_idx][1];
  assign bus.pred_target = target_mem[look_idx];

  // Resolution port from EX
  logic [IDX-1:0]  upd_idx;
  logic [TAGW-1:0] upd_tag;
  logic            upd_hit;

  assign upd_idx = bus.upd_pc[IDX+1:2];
  assign upd_tag = bus.upd_pc[XLEN-1:IDX+2];
  assign upd_hit = valid_q[upd_idx] && (tag_mem[upd_idx] == upd_tag);

  // Fetch addresses are word aligned, so the byte-offset bits are dropped.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{bus.upd_pc[1:0], bus.redirect_pc[1:0]};

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_pc = pc_q;
    if (bus.redirect_valid) begin
      next_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};
    end else if (!bus.pc_write) begin
      next_pc = pc_q;
    end else if (bus.pred_taken) begin
      next_pc = bus.pred_target;
    end else begin
      next_pc = pc_q + XLEN'(4);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= next_pc;
    end
  end

  // NOTE: only valid bits and counters are reset; tag/target storage needs no
  // reset because an invalid entry is never consulted, keeping it plain RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        ctr_q[i] <= CTR_WEAK_NT;
      end
    end else if (bus.upd_valid) begin
      if (bus.upd_taken) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= upd_hit ? sat_inc(ctr_q[upd_idx]) : CTR_WEAK_T;
      end else if (upd_hit) begin
        ctr_q[upd_idx]   <= sat_dec(ctr_q[upd_idx]);
      end
    end
  end

  // A taken resolution either refreshes the hit entry or evicts the old one.
  always_ff @(posedge clk) begin
    if (bus.upd_valid && bus.upd_taken) begin
      tag_mem[upd_idx]    <= upd_tag;
      target_mem[upd_idx] <= bus.upd_target;
    end
  end

endmodule

// File: tb/tb_pc_predict_gen.sv
// Randomised and directed bench for pc_predict_gen against a behavioural
// branch-predictor model kept in plain arrays and integer arithmetic.
module tb_pc_predict_gen;

  localparam int N = 16;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pc_predict_gen_if #(.XLEN(32)) bus ();

  pc_predict_gen #(
    .XLEN(32),
    .RESET_PC(32'h0),
    .BTB_ENTRIES(N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the predictor as the rules describe it
  logic [31:0] m_pc;
  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 4) % N);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / (4 * N);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic model_lookup(output bit taken, output logic [31:0] target);
    int i;
    i      = idx_of(m_pc);
    taken  = m_valid[i] && (m_tag[i] == tag_of(m_pc)) && (m_ctr[i] >= 2);
    target = m_tgt[i];
  endtask

  task automatic model_step();
    bit          t;
    logic [31:0] tg;
    logic [31:0] nxt;
    int          i;
    bit          hit;
    model_lookup(t, tg);
    if (bus.redirect_valid)  nxt = bus.redirect_pc - (bus.redirect_pc % 4);
    else if (!bus.pc_write)  nxt = m_pc;
    else if (t)              nxt = tg;
    else                     nxt = m_pc + 32'd4;
    if (bus.upd_valid) begin
      i   = idx_of(bus.upd_pc);
      hit = m_valid[i] && (m_tag[i] == tag_of(bus.upd_pc));
      if (bus.upd_taken) begin
        m_ctr[i]   = hit ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1) : 2;
        m_valid[i] = 1;
        m_tag[i]   = tag_of(bus.upd_pc);
        m_tgt[i]   = bus.upd_target;
      end else if (hit) begin
        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end
    end
    m_pc = nxt;
  endtask

  task automatic drive(input bit pw, input bit rv, input logic [31:0] rpc,
                       input bit uv, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utg);
    bus.pc_write       = pw;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.upd_valid      = uv;
    bus.upd_pc         = upc;
    bus.upd_taken      = ut;
    bus.upd_target     = utg;
  endtask

  task automatic idle();
    drive(1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (bus.pc !== 32'h0) begin
      $display("FAIL reset_pc got=%h want=%h", bus.pc, 32'h0);
      bad++;
    end
    total++;
    if (bus.pred_taken !== 1'b0) begin
      $display("FAIL reset_pred got=%b want=0", bus.pred_taken);
      bad++;
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3] = '{32'h4, 32'h8, 32'hC};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (bus.pc !== exp_pc[k] || bus.pc !== m_pc) begin
        $display("FAIL seq_pc[%0d] got=%h want=%h", k, bus.pc, exp_pc[k]);
        bad++;
      end
      total++;
      if (bus.pred_taken !== 1'b0) begin
        $display("FAIL seq_pred[%0d] got=%b want=0", k, bus.pred_taken);
        bad++;
      end
    end
  endtask

  task automatic test_install_taken();
    logic [31:0] exp_pc [5] = '{32'h4, 32'h8, 32'hC, 32'h10, 32'h40};
    do_reset();
    drive(1, 1, 32'h0, 1, 32'h10, 1, 32'h40);
    tick();
    idle();
    total++;
    if (bus.pc !== 32'h0) begin
      $display("FAIL install_restart got=%h want=%h", bus.pc, 32'h0);
      bad++;
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (bus.pc !== exp_pc[k] || bus.pc !== m_pc) begin
        $display("FAIL install_pc[%0d] got=%h want=%h", k, bus.pc, exp_pc[k]);
        bad++;
      end
      if (k == 3) begin
        total++;
        if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h40) begin
          $display("FAIL install_pred got=%b/%h want=1/%h",
                   bus.pred_taken, bus.pred_target, 32'h40);
          bad++;
        end
      end
    end
  endtask

  task automatic test_redirect_stall();
    drive(0, 1, 32'h83, 0, 32'h0, 0, 32'h0);
    tick();
    total++;
    if (bus.pc !== 32'h80) begin
      $display("FAIL redirect_over_stall got=%h want=%h", bus.pc, 32'h80);
      bad++;
    end
    drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    tick();
    tick();
    total++;
    if (bus.pc !== 32'h80) begin
      $display("FAIL stall_hold got=%h want=%h", bus.pc, 32'h80);
      bad++;
    end
    idle();
  endtask

  task automatic test_saturation();
    bit exp_pred [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 32'h10, 1, 32'h10, 1, 32'h40);
      tick();
      total++;
      if (bus.pred_taken !== 1'b1) begin
        $display("FAIL sat_taken[%0d] got=%b want=1", k, bus.pred_taken);
        bad++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 32'h10, 1, 32'h10, 0, 32'h0);
      tick();
      total++;
      if (bus.pred_taken !== exp_pred[k]) begin
        $display("FAIL sat_nt[%0d] got=%b want=%b", k, bus.pred_taken, exp_pred[k]);
        bad++;
      end
    end
    idle();
    tick();
    total++;
    if (bus.pc !== 32'h14) begin
      $display("FAIL sat_fallthru got=%h want=%h", bus.pc, 32'h14);
      bad++;
    end
  endtask

  task automatic test_alias();
    do_reset();
    drive(0, 0, 32'h0, 1, 32'h10, 1, 32'h40);
    tick();
    drive(0, 0, 32'h0, 1, 32'h10 + 4 * N, 1, 32'h200);
    tick();
    drive(1, 1, 32'h10, 0, 32'h0, 0, 32'h0);
    tick();
    total++;
    if (bus.pred_taken !== 1'b0) begin
      $display("FAIL alias_evicted got=%b want=0", bus.pred_taken);
      bad++;
    end
    idle();
    tick();
    total++;
    if (bus.pc !== 32'h14) begin
      $display("FAIL alias_next got=%h want=%h", bus.pc, 32'h14);
      bad++;
    end
    drive(1, 1, 32'h10 + 4 * N, 0, 32'h0, 0, 32'h0);
    tick();
    total++;
    if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h200) begin
      $display("FAIL alias_new got=%b/%h want=1/%h",
               bus.pred_taken, bus.pred_target, 32'h200);
      bad++;
    end
    idle();
  endtask

  task automatic test_wrap_and_reset();
    drive(1, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0);
    tick();
    idle();
    tick();
    total++;
    if (bus.pc !== 32'h0) begin
      $display("FAIL wrap got=%h want=%h", bus.pc, 32'h0);
      bad++;
    end
    // Stall with a redirect and an update pending, then reset between edges.
    drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    tick();
    drive(0, 1, 32'h100, 1, 32'h20, 1, 32'h300);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.pc !== 32'h0) begin
      $display("FAIL async_reset_pc got=%h want=%h", bus.pc, 32'h0);
      bad++;
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.pc !== 32'h0) begin
      $display("FAIL reset_held_pc got=%h want=%h", bus.pc, 32'h0);
      bad++;
    end
    rst = 1'b0;
    model_reset();
    drive(1, 1, 32'h10 + 4 * N, 0, 32'h0, 0, 32'h0);
    tick();
    total++;
    if (bus.pred_taken !== 1'b0) begin
      $display("FAIL reset_btb_clear got=%b want=0", bus.pred_taken);
      bad++;
    end
    drive(1, 1, 32'h20, 0, 32'h0, 0, 32'h0);
    tick();
    total++;
    if (bus.pred_taken !== 1'b0) begin
      $display("FAIL reset_drops_update got=%b want=0", bus.pred_taken);
      bad++;
    end
    idle();
  endtask

  task automatic test_random();
    bit          et;
    logic [31:0] eg;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(9, 0) < 8,
            $urandom_range(9, 0) == 0, $urandom_range(32'h1FF, 0),
            $urandom_range(1, 0) == 1, $urandom_range(32'h1FF, 0),
            $urandom_range(2, 0) != 0, $urandom_range(32'h7F, 0) * 4);
      tick();
      model_lookup(et, eg);
      total++;
      if (bus.pc !== m_pc) begin
        $display("FAIL rand_pc[%0d] got=%h want=%h", k, bus.pc, m_pc);
        bad++;
      end
      total++;
      if (bus.pred_taken !== et || (et && bus.pred_target !== eg)) begin
        $display("FAIL rand_pred[%0d] got=%b/%h want=%b/%h",
                 k, bus.pred_taken, bus.pred_target, et, eg);
        bad++;
      end
    end
    idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle();
    model_reset();
    #12;
    test_reset();
    test_sequential();
    test_install_taken();
    test_redirect_stall();
    test_saturation();
    test_alias();
    test_wrap_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
